// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NUM_REQ writeback sources.
// Optional forwarding of the in-flight write to decode: define REGFILE_WRITE_ARBITER_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_Stall,
  input  logic [NUM_REQ-1:0]      i_ReqValid,
  input  logic [5*NUM_REQ-1:0]    i_ReqRegDest,
  input  logic [32*NUM_REQ-1:0]   i_ReqData,
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
  input  logic [4:0]              i_RegSource1,
  input  logic [4:0]              i_RegSource2,
  output logic                    o_Fwd1Valid,
  output logic                    o_Fwd2Valid,
  output logic [31:0]             o_Fwd1Data,
  output logic [31:0]             o_Fwd2Data,
`endif
  output logic [NUM_REQ-1:0]      o_ReqReady,
  output logic                    o_WriteEnable,
  output logic [4:0]              o_RegDest,
  output logic [31:0]             o_DataIn,
  output logic                    o_Busy
);

  // Handshake: a requester raises valid independently of ready and holds valid,
  // RegDest and Data stable until its ready bit is high; a transfer happens in
  // any cycle where valid and ready are both high for that requester.

  logic [PTR_W-1:0] r_Last;
  logic [PTR_W-1:0] w_GrantIdx;
  logic [PTR_W-1:0] w_Cand;
  logic             w_Found;
  logic             w_Transfer;
  logic [4:0]       w_Dest;
  logic [31:0]      w_Data;

  // Search upward from the slot after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    w_Found    = 1'b0;
    w_GrantIdx = '0;
    w_Cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_Cand = PTR_W'((int'(r_Last) + i) % NUM_REQ);
      if (!w_Found && i_ReqValid[w_Cand]) begin
        w_Found    = 1'b1;
        w_GrantIdx = w_Cand;
      end
    end
  end

  always_comb begin
    w_Dest = '0;
    w_Data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_GrantIdx == PTR_W'(k)) begin
        w_Dest = i_ReqRegDest[5*k +: 5];
        w_Data = i_ReqData[32*k +: 32];
      end
    end
  end

  assign w_Transfer = w_Found && !i_Stall && i_Reset_n;
  assign o_ReqReady = w_Transfer ? (NUM_REQ'(1) << w_GrantIdx) : '0;
  assign o_Busy     = (|i_ReqValid) && !w_Transfer;

  // Writes to x0 are acknowledged but never reach the register file.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Last        <= PTR_W'(NUM_REQ - 1);
      o_WriteEnable <= 1'b0;
      o_RegDest     <= '0;
      o_DataIn      <= '0;
    end else if (w_Transfer) begin
      r_Last        <= w_GrantIdx;
      o_WriteEnable <= (w_Dest != 5'd0);
      o_RegDest     <= w_Dest;
      o_DataIn      <= w_Data;
    end else begin
      o_WriteEnable <= 1'b0;
    end
  end

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
  assign o_Fwd1Valid = o_WriteEnable && (i_RegSource1 == o_RegDest) && (i_RegSource1 != 5'd0);
  assign o_Fwd2Valid = o_WriteEnable && (i_RegSource2 == o_RegDest) && (i_RegSource2 != 5'd0);
  assign o_Fwd1Data  = o_DataIn;
  assign o_Fwd2Data  = o_DataIn;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (NUM_REQ=3): directed vectors, expected grants/writes queued.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [2:0]  valid;
  logic [4:0]  dest [3];
  logic [31:0] data [3];
  logic [14:0] reqRegDest;
  logic [95:0] reqData;
  logic [2:0]  reqReady;
  logic        writeEnable;
  logic [4:0]  regDest;
  logic [31:0] dataIn;
  logic        busy;
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        fwd1Valid;
  logic        fwd2Valid;
  logic [31:0] fwd1Data;
  logic [31:0] fwd2Data;
`endif

  assign reqRegDest = {dest[2], dest[1], dest[0]};
  assign reqData    = {data[2], data[1], data[0]};

  regfile_write_arbiter #(.NUM_REQ(3)) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Stall      (stall),
    .i_ReqValid   (valid),
    .i_ReqRegDest (reqRegDest),
    .i_ReqData    (reqData),
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    .i_RegSource1 (src1),
    .i_RegSource2 (src2),
    .o_Fwd1Valid  (fwd1Valid),
    .o_Fwd2Valid  (fwd2Valid),
    .o_Fwd1Data   (fwd1Data),
    .o_Fwd2Data   (fwd2Data),
`endif
    .o_ReqReady   (reqReady),
    .o_WriteEnable(writeEnable),
    .o_RegDest    (regDest),
    .o_DataIn     (dataIn),
    .o_Busy       (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: {ready one-hot, we, dest, data}
  logic [40:0] exp_q[$];
  logic [40:0] pendExp;
  bit          pend;
  int          nChecks;
  int          nFail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] rdy, input logic [4:0] d, input logic [31:0] v);
    exp_q.push_back({rdy, (d != 5'd0), d, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] d, input logic [31:0] v);
    dest[k] = d;
    data[k] = v;
  endtask

  // Monitor: checks each transfer's grant, then the register file write one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("write_we",   {31'd0, writeEnable}, {31'd0, pendExp[37]});
        check("write_dest", {27'd0, regDest},     {27'd0, pendExp[36:32]});
        check("write_data", dataIn,               pendExp[31:0]);
      end else begin
        check("idle_we", {31'd0, writeEnable}, 32'd0);
      end
      pend = 1'b0;
      if (|(reqReady & valid)) begin
        if (exp_q.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpected_grant: got ready 0x%0h expected no transfer at %0t", reqReady, $time);
        end else begin
          pendExp = exp_q.pop_front();
          check("grant", {29'd0, reqReady}, {29'd0, pendExp[40:38]});
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    nChecks = 0;
    nFail   = 0;
    pend    = 1'b0;
    rst_n   = 1'b0;
    stall   = 1'b0;
    valid   = 3'b111;
    for (int k = 0; k < 3; k++) set_req(k, 5'd0, 32'd0);
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    src1 = 5'd0;
    src2 = 5'd0;
`endif

    // Reset state, with requests already pending
    #2;
    check("rst_ready", {29'd0, reqReady},    32'd0);
    check("rst_we",    {31'd0, writeEnable}, 32'd0);
    check("rst_dest",  {27'd0, regDest},     32'd0);
    check("rst_data",  dataIn,               32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All three valid for 6 cycles: 0,1,2,0,1,2
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);
    for (int r = 0; r < 2; r++) begin
      push_exp(3'b001, 5'd1, 32'hA);
      push_exp(3'b010, 5'd2, 32'hB);
      push_exp(3'b100, 5'd3, 32'hC);
    end
    repeat (6) tick();
    valid = 3'b000;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    tick();

    // Requester 1 alone, write to x0 is acknowledged but suppressed
    set_req(1, 5'd0, 32'hDEADBEEF);
    valid = 3'b010;
    push_exp(3'b010, 5'd0, 32'hDEADBEEF);
    @(negedge clk);
    check("x0_ready", {29'd0, reqReady}, 32'h2);
    tick();
    valid = 3'b000;
    tick();

    // Stall with all valid: no grants, busy, pointer frozen at 1
    set_req(0, 5'd4, 32'h40);
    set_req(1, 5'd5, 32'h50);
    set_req(2, 5'd6, 32'h60);
    stall = 1'b1;
    valid = 3'b111;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", {29'd0, reqReady}, 32'd0);
      check("stall_busy",  {31'd0, busy},     32'd1);
      tick();
    end
    push_exp(3'b100, 5'd6, 32'h60);
    stall = 1'b0;
    @(negedge clk);
    check("release_busy", {31'd0, busy}, 32'd0);
    tick();
    valid = 3'b000;
    tick();

    // Grant to requester 2, then asynchronous reset discards the held write
    set_req(2, 5'd5, 32'h1234);
    valid = 3'b100;
    push_exp(3'b100, 5'd5, 32'h1234);
    tick();
    valid = 3'b000;
    check("pre_rst_we",   {31'd0, writeEnable}, 32'd1);
    check("pre_rst_dest", {27'd0, regDest},     32'd5);
    check("pre_rst_data", dataIn,               32'h1234);
    #2;
    rst_n = 1'b0;
    set_req(0, 5'd7, 32'h70);
    set_req(1, 5'd8, 32'h80);
    set_req(2, 5'd9, 32'h90);
    valid = 3'b111;
    #1;
    check("async_rst_we",    {31'd0, writeEnable}, 32'd0);
    check("async_rst_dest",  {27'd0, regDest},     32'd0);
    check("async_rst_data",  dataIn,               32'd0);
    check("async_rst_ready", {29'd0, reqReady},    32'd0);
    push_exp(3'b001, 5'd7, 32'h70);
    tick();
    rst_n = 1'b1;
    tick();

    // Requester 0 alone for 4 cycles: back-to-back grants
    for (int i = 0; i < 4; i++) begin
      set_req(0, 5'(10 + i), 32'h100 + i);
      valid = 3'b001;
      push_exp(3'b001, 5'(10 + i), 32'h100 + i);
      tick();
    end

    // Requesters 0 and 2 with pointer at 0: 2 first, then wrap to 0
    set_req(0, 5'd20, 32'hAAAA0000);
    set_req(2, 5'd21, 32'hBBBB0000);
    valid = 3'b101;
    push_exp(3'b100, 5'd21, 32'hBBBB0000);
    push_exp(3'b001, 5'd20, 32'hAAAA0000);
    repeat (2) tick();
    valid = 3'b000;
    tick();

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    // In-flight write x7=0x55 forwarded to source 1 only
    set_req(0, 5'd7, 32'h55);
    valid = 3'b001;
    src1  = 5'd7;
    src2  = 5'd0;
    push_exp(3'b001, 5'd7, 32'h55);
    tick();
    valid = 3'b000;
    check("fwd1_valid", {31'd0, fwd1Valid}, 32'd1);
    check("fwd1_data",  fwd1Data,           32'h55);
    check("fwd2_valid", {31'd0, fwd2Valid}, 32'd0);
    tick();
`endif

    // Bounded drain of the expected queue
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    repeat (2) tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
